// File: rtl/uart_pkg.sv
// Shared constants, state encodings and baud divisor helper for the trigger-command UART.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE    = 8'h53;
    localparam logic [7:0] OPC_SET_TRIG = 8'h00;

    localparam logic [1:0] BAUD_9600 = 2'b11;
    localparam logic [1:0] BAUD_2400 = 2'b10;
    localparam logic [1:0] BAUD_600  = 2'b01;
    localparam logic [1:0] BAUD_110  = 2'b00;

    // Wide enough for the slowest rate (110 baud at 12 MHz needs 109091).
    localparam int unsigned CNT_W = 17;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {PkIdle, PkSend, PkGap} pk_state_e;

    // Cycles per bit, rounded to nearest.
    function automatic logic [CNT_W-1:0] baud_div(input int unsigned clk_hz, input logic [1:0] baud);
        int unsigned rate;
        case (baud)
            BAUD_9600: rate = 9600;
            BAUD_2400: rate = 2400;
            BAUD_600:  rate = 600;
            default:   rate = 110;
        endcase
        return CNT_W'((clk_hz + rate / 2) / rate);
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 frame serializer. A load is taken while o_ready is high, which includes the last
// cycle of a stop bit so consecutive frames abut with no idle cycle.
module uart_tx_byte
    import uart_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_div,
    input  logic             i_load,
    input  logic [7:0]       i_data,
    output logic             o_ready,
    output logic             o_tx
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    tx_state_e        r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [CNT_W-1:0] r_div, w_div_d;
    logic [2:0]       r_bit, w_bit_d;
    logic [7:0]       r_shift, w_shift_d;
    logic             r_tx, w_tx_d;
    logic             w_tick;

    assign w_tick  = (r_cnt == '0);
    assign o_ready = (r_state == TxIdle) || ((r_state == TxStop) && w_tick);
    assign o_tx    = r_tx;

    // Next-state: walk start, data and stop bits, each lasting r_div cycles.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_div_d   = r_div;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_tx_d    = r_tx;
        if (r_state != TxIdle) begin
            w_cnt_d = w_tick ? (r_div - CNT_ONE) : (r_cnt - CNT_ONE);
        end
        unique case (r_state)
            TxIdle: ;
            TxStart: begin
                if (w_tick) begin
                    w_state_d = TxData;
                    w_tx_d    = r_shift[0];
                end
            end
            TxData: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) begin
                        w_state_d = TxStop;
                        w_tx_d    = 1'b1;
                    end else begin
                        w_bit_d   = r_bit + 3'd1;
                        w_shift_d = r_shift >> 1;
                        w_tx_d    = r_shift[1];
                    end
                end
            end
            TxStop: begin
                if (w_tick) begin
                    w_state_d = TxIdle;
                    w_cnt_d   = '0;
                end
            end
            default: w_state_d = TxIdle;
        endcase
        if (i_load && o_ready) begin
            w_state_d = TxStart;
            w_tx_d    = 1'b0;
            w_cnt_d   = i_div - CNT_ONE;
            w_div_d   = i_div;
            w_shift_d = i_data;
            w_bit_d   = 3'd0;
        end
    end

    // State register with synchronous reset to an idle mark line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= TxIdle;
            r_cnt   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_div   <= w_div_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
            r_tx    <= w_tx_d;
        end
    end

endmodule

// File: rtl/uart_trig_cmd_tx.sv
// Trigger-command transmitter: sends 0x53, opcode, channel, value as 8N1 frames with optional
// mark gap after each stop bit. Inputs are latched when a request is accepted.
module uart_trig_cmd_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 12_000_000,
    parameter int unsigned GAP_BITS = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_baud,
    input  logic       i_start,
    input  logic [7:0] i_opcode,
    input  logic [1:0] i_chan,
    input  logic [7:0] i_value,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_byte_idx
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    pk_state_e        r_state, w_state_d;
    logic [1:0]       r_idx, w_idx_d;
    logic [7:0]       r_opcode, w_opcode_d;
    logic [1:0]       r_chan, w_chan_d;
    logic [7:0]       r_value, w_value_d;
    logic [CNT_W-1:0] r_div, w_div_d;
    logic [CNT_W-1:0] r_gcnt, w_gcnt_d;
    logic [3:0]       r_gbits, w_gbits_d;
    logic             r_done, w_done_d;

    logic             w_ready, w_load, w_byte_end;
    logic [7:0]       w_load_data, w_next_byte;
    logic [CNT_W-1:0] w_load_div;

    assign o_busy     = (r_state != PkIdle);
    assign o_done     = r_done;
    assign o_byte_idx = r_idx;

    uart_tx_byte u_tx_byte (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_div   (w_load_div),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .o_ready (w_ready),
        .o_tx    (o_tx)
    );

    // Byte that follows the one currently indexed.
    always_comb begin
        w_next_byte = SYNC_BYTE;
        case (r_idx)
            2'd0:    w_next_byte = r_opcode;
            2'd1:    w_next_byte = {6'b0, r_chan};
            2'd2:    w_next_byte = r_value;
            default: w_next_byte = SYNC_BYTE;
        endcase
    end

    // Packet sequencing: accept request, wait for each frame and gap, chain the next byte.
    always_comb begin
        w_state_d   = r_state;
        w_idx_d     = r_idx;
        w_opcode_d  = r_opcode;
        w_chan_d    = r_chan;
        w_value_d   = r_value;
        w_div_d     = r_div;
        w_gcnt_d    = r_gcnt;
        w_gbits_d   = r_gbits;
        w_done_d    = 1'b0;
        w_load      = 1'b0;
        w_load_data = SYNC_BYTE;
        w_load_div  = r_div;
        w_byte_end  = 1'b0;
        unique case (r_state)
            PkIdle: begin
                if (i_start) begin
                    w_load     = 1'b1;
                    w_load_div = baud_div(CLK_HZ, i_baud);
                    w_div_d    = w_load_div;
                    w_opcode_d = i_opcode;
                    w_chan_d   = i_chan;
                    w_value_d  = i_value;
                    w_idx_d    = 2'd0;
                    w_state_d  = PkSend;
                end
            end
            PkSend: begin
                // Serializer is never idle here, so ready marks the end of a stop bit.
                if (w_ready) begin
                    if (GAP_BITS != 0) begin
                        w_state_d = PkGap;
                        w_gcnt_d  = r_div - CNT_ONE;
                        w_gbits_d = 4'(GAP_BITS - 1);
                    end else begin
                        w_byte_end = 1'b1;
                    end
                end
            end
            PkGap: begin
                if (r_gcnt == '0) begin
                    if (r_gbits == '0) begin
                        w_byte_end = 1'b1;
                    end else begin
                        w_gbits_d = r_gbits - 4'd1;
                        w_gcnt_d  = r_div - CNT_ONE;
                    end
                end else begin
                    w_gcnt_d = r_gcnt - CNT_ONE;
                end
            end
            default: w_state_d = PkIdle;
        endcase
        if (w_byte_end) begin
            if (r_idx == 2'd3) begin
                w_state_d = PkIdle;
                w_idx_d   = 2'd0;
                w_done_d  = 1'b1;
            end else begin
                w_state_d   = PkSend;
                w_load      = 1'b1;
                w_load_data = w_next_byte;
                w_idx_d     = r_idx + 2'd1;
            end
        end
    end

    // Packet state register; reset abandons any packet in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= PkIdle;
            r_idx    <= '0;
            r_opcode <= '0;
            r_chan   <= '0;
            r_value  <= '0;
            r_div    <= '0;
            r_gcnt   <= '0;
            r_gbits  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_idx    <= w_idx_d;
            r_opcode <= w_opcode_d;
            r_chan   <= w_chan_d;
            r_value  <= w_value_d;
            r_div    <= w_div_d;
            r_gcnt   <= w_gcnt_d;
            r_gbits  <= w_gbits_d;
            r_done   <= w_done_d;
        end
    end

endmodule

// File: tb/tb_uart_trig_cmd_tx.sv
// Bench for uart_trig_cmd_tx: scaled-down clock so every rate fits in a short run; the expected
// line level for each cycle is derived from the packet bytes, bit position and divisor.
module tb_uart_trig_cmd_tx;

    localparam int unsigned TB_CLK_HZ = 24_000;
    localparam int unsigned TB_GAP    = 2;
    localparam int          BPB       = 10 + TB_GAP;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [1:0] baud, ch, bidx;
    logic [7:0] opc, val;
    logic       tx, busy, done;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int exp_done = 0;

    always #5 clk = ~clk;

    uart_trig_cmd_tx #(
        .CLK_HZ   (TB_CLK_HZ),
        .GAP_BITS (TB_GAP)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_baud     (baud),
        .i_start    (start),
        .i_opcode   (opc),
        .i_chan     (ch),
        .i_value    (val),
        .o_tx       (tx),
        .o_busy     (busy),
        .o_done     (done),
        .o_byte_idx (bidx)
    );

    // Count done pulses for the whole run.
    always @(negedge clk) if (done === 1'b1) n_done++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_div(input logic [1:0] b);
        real rate;
        case (b)
            2'b11:   rate = 9600.0;
            2'b10:   rate = 2400.0;
            2'b01:   rate = 600.0;
            default: rate = 110.0;
        endcase
        return $rtoi(real'(TB_CLK_HZ) / rate + 0.5);
    endfunction

    // ev_kind: 0 none, 1 change inputs, 2 pulse start, 3 reset (packet abandoned).
    task automatic send_pkt(input logic [1:0] b_in, input logic [7:0] o_in, input logic [1:0] c_in,
                            input logic [7:0] v_in, input int ev_kind, input int ev_cycle,
                            input bit keep_start);
        logic [7:0] pb [4];
        int div, len, match, busy_n, idx_n, done_n;
        bit clr;
        div = model_div(b_in);
        len = 4 * BPB * div;
        pb[0] = 8'h53;
        pb[1] = o_in;
        pb[2] = {6'b0, c_in};
        pb[3] = v_in;
        baud = b_in; opc = o_in; ch = c_in; val = v_in; start = 1'b1;
        @(negedge clk);
        if (!keep_start) start = 1'b0;
        match = 0; busy_n = 0; idx_n = 0; done_n = 0; clr = 1'b0;
        for (int c = 0; c < len; c++) begin
            int k, by, pos;
            logic e;
            k   = c / div;
            by  = k / BPB;
            pos = k % BPB;
            e   = (pos == 0) ? 1'b0 : ((pos <= 8) ? pb[by][pos-1] : 1'b1);
            if (tx === e) match++;
            if (busy === 1'b1) busy_n++;
            if (bidx === 2'(by)) idx_n++;
            if (done !== 1'b0) done_n++;
            if (c % div == div - 1) begin
                check($sformatf("bit byte%0d pos%0d", by, pos), match, div);
                match = 0;
            end
            if (c % (BPB * div) == BPB * div - 1) begin
                check($sformatf("byte_idx %0d", by), idx_n, BPB * div);
                idx_n = 0;
            end
            if (clr) begin
                start = 1'b0;
                clr   = 1'b0;
            end
            if (c == ev_cycle) begin
                case (ev_kind)
                    1: begin
                        baud = ~b_in;
                        opc  = 8'($urandom);
                        ch   = 2'($urandom);
                        val  = 8'($urandom);
                    end
                    2: begin
                        start = 1'b1;
                        clr   = 1'b1;
                    end
                    3: begin
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        check("rst tx", tx, 1);
                        check("rst busy", busy, 0);
                        check("rst done", done, 0);
                        check("busy before rst", busy_n, c + 1);
                        return;
                    end
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        check("busy in packet", busy_n, len);
        check("no early done", done_n, 0);
        check("done pulse", done, 1);
        check("busy after", busy, 0);
        check("tx after", tx, 1);
        check("byte_idx after", bidx, 0);
        exp_done++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; baud = 2'b11; opc = '0; ch = '0; val = '0;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset byte_idx", bidx, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fixed packet at the fastest rate.
        send_pkt(2'b11, 8'h00, 2'd1, 8'hAB, 0, -1, 1'b0);
        @(negedge clk);
        check("done one cycle", done, 0);

        // Slowest rate; inputs including baud changed inside byte 1.
        send_pkt(2'b00, 8'($urandom), 2'($urandom), 8'($urandom), 1, model_div(2'b00) * (BPB + 3), 1'b0);
        @(negedge clk);

        // Start pulse during byte 2 must be ignored.
        send_pkt(2'b10, 8'($urandom), 2'($urandom), 8'($urandom), 2, model_div(2'b10) * (2 * BPB + 4), 1'b0);
        @(negedge clk);
        check("ignored start", busy, 0);

        // Start held high through packet and done cycle: back-to-back packets.
        send_pkt(2'b01, 8'($urandom), 2'($urandom), 8'($urandom), 0, -1, 1'b1);
        send_pkt(2'b11, 8'($urandom), 2'($urandom), 8'($urandom), 0, -1, 1'b0);
        @(negedge clk);
        check("b2b done one cycle", done, 0);

        // Reset during data bits of byte 1, then a clean packet.
        send_pkt(2'b10, 8'($urandom), 2'($urandom), 8'($urandom), 3, model_div(2'b10) * (BPB + 4) + 3, 1'b0);
        repeat (20) @(negedge clk);
        check("idle after rst busy", busy, 0);
        check("idle after rst tx", tx, 1);
        send_pkt(2'b01, 8'($urandom), 2'($urandom), 8'($urandom), 0, -1, 1'b0);
        @(negedge clk);

        // Reset and start together: reset wins.
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst+start busy", busy, 0);
        check("rst+start tx", tx, 1);
        @(negedge clk);
        check("rst+start later busy", busy, 0);

        // Random packets at the faster rates.
        for (int i = 0; i < 4; i++) begin
            send_pkt(2'($urandom_range(3, 1)), 8'($urandom), 2'($urandom), 8'($urandom), 0, -1, 1'b0);
            repeat ($urandom_range(3, 1)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("done pulse count", n_done, exp_done);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_trig_cmd_tx.md
# uart_trig_cmd_tx

Host-side UART command transmitter: on a one-cycle `start` request it serializes a 4-byte trigger command packet (sync 0x53, opcode, channel, value) as 8N1 frames on `tx`, at one of four selectable baud rates derived from the 12 MHz system clock. It is the sending end of the trigger-command link: its output connects to the `rx` input of the UART trigger receiver/buffer, and it replaces hand-built rx stimulus in system benches and on-board loopback.

## Interface
- `CLK_HZ`, 12_000_000, system clock frequency used to derive bit divisors
- `GAP_BITS`, 0, extra idle (mark) bit-times inserted after every stop bit, 0..15
- `clk`  in  1  system clock, 12 MHz
- `rst`  in  1  reset; synchronous and active-high
- `baud`  in  2  rate select: 2'b11=9600, 2'b10=2400, 2'b01=600, 2'b00=110
- `start`  in  1  packet request; accepted only when `busy`=0
- `opcode`  in  8  byte 1 of the packet (0x00 = set trigger)
- `chan`  in  2  trigger channel 0..3, sent as byte 2 zero-extended
- `value`  in  8  byte 3 of the packet (trigger value)
- `tx`  out  1  serial line, idle high
- `busy`  out  1  high while a packet is in flight
- `done`  out  1  one-cycle pulse at packet completion
- `byte_idx`  out  2  index (0..3) of the byte currently on the line

## Operation
- Divisor per bit: DIV = round(CLK_HZ/rate); at 12 MHz: 9600→1250, 2400→5000, 600→20000, 110→109091. Bit counter 17 bits wide, counts DIV-1 down to 0.
- On accepted `start`: latch `baud`, `opcode`, `chan`, `value`; later input changes do not affect the packet in flight.
- `start` while `busy`=1: ignored, no queueing.
- Packet order: 0x53, `opcode`, {6'b0,`chan`}, `value`.
- Each byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), then GAP_BITS mark bit-times.
- FSM: IDLE → START → DATA (8 bits, bit counter 0..7) → STOP → GAP (skipped if GAP_BITS=0) → START for next byte, or → IDLE after byte 3.
- `byte_idx` increments when the next byte's start bit begins; 0 in IDLE.
- Reset values: `tx`=1, `busy`=0, `done`=0, `byte_idx`=0, FSM IDLE, counters 0.

## Timing
- `start` sampled high at edge N (IDLE) → `tx`=0 and `busy`=1 from edge N+1.
- Every bit lasts exactly DIV cycles; no drift across the packet.
- Packet length: 4·(10+GAP_BITS)·DIV cycles from first start-bit edge.
- At the edge where the final stop/gap bit-time ends: `busy`→0 and `done`=1 for exactly one cycle; `tx` stays 1.
- `start` high in the `done` cycle is accepted (busy=0): next start bit begins the following edge, giving back-to-back packets with zero extra idle.
- `rst` mid-frame: next edge forces `tx`=1, `busy`=0, `done`=0; partial packet abandoned, no `done`.
- `rst` and `start` same cycle: reset wins, request dropped.

## Structure
- Shared package `uart_pkg`: SYNC_BYTE=8'h53, OPC_SET_TRIG=8'h00, baud codes, divisor function/constants for CLK_HZ, FSM state encoding.
- One sub-module: `uart_tx_byte` (single 8N1 frame serializer with DIV input, `load`/`ready` handshake); top handles packet sequencing, gap, `byte_idx`, `done`.

## Test plan
- Reset, baud=2'b11, start with opcode=0x00, chan=1, value=0xAB → line decodes 0x53,0x00,0x01,0xAB; each bit 1250 cycles; `done` once at 40·1250 cycles after first start bit.
- baud=2'b00, single packet → bit width exactly 109091 cycles; baud changed to 2'b11 mid-packet → width unchanged.
- `start` pulsed during byte 2 → ignored; only one packet, one `done`.
- `start` held high across `done` → second packet's start bit immediately follows first packet's last stop bit; two `done` pulses.
- GAP_BITS=4, baud=2'b10 → 4×5000 mark cycles after every stop bit; packet = 4·14·5000 cycles.
- `rst` asserted during data bits of byte 1 → `tx`=1, `busy`=0 next cycle, no `done`; subsequent start sends a full correct packet.
